// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and frame launcher feeding a UART transmitter.
// Optional almost_full output: define UART_TX_FIFO_AFULL_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flush,
  input  logic                  clr_ovf,
  input  logic                  tx_done,
  output logic                  tx_te,
  output logic [DATA_WIDTH-1:0] tx_dr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
`ifdef UART_TX_FIFO_AFULL_EN
  output logic                  almost_full,
`endif
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("AFULL_LEVEL out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_GAP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   w_cnt_nxt;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_ovf_set;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign busy  = (r_state != S_IDLE);

  // flush discards a same-cycle write without flagging it
  assign w_wr      = wr_en & ~full & ~flush;
  assign w_ovf_set = wr_en & full & ~flush;
  assign w_pop     = (r_state == S_LOAD);

  always_comb begin
    w_cnt_nxt = count;
    if (flush)
      w_cnt_nxt = '0;
    else if (w_wr && !w_pop)
      w_cnt_nxt = count + CNT_ONE;
    else if (!w_wr && w_pop)
      w_cnt_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr)
          r_wptr <= r_wptr + ADDR_WIDTH'(1);
        if (w_pop)
          r_rptr <= r_rptr + ADDR_WIDTH'(1);
      end
      count <= w_cnt_nxt;
      if (w_ovf_set)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_AFULL_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      almost_full <= 1'b0;
    else
      almost_full <= (w_cnt_nxt >= AF_CNT);
  end
`endif

  // GAP holds tx_te low until the transmitter has seen it low while enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      tx_te   <= 1'b0;
      tx_dr   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          tx_te <= 1'b0;
          if (!empty && !flush)
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          tx_dr   <= r_mem[r_rptr];
          r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          tx_te   <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            tx_te   <= 1'b0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          tx_te <= 1'b0;
          if (tx_en)
            r_state <= S_IDLE;
        end
        default: begin
          tx_te   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queued expected bytes,
// launch monitor, randomized transmitter tx_done responder.
module tb_uart_tx_fifo;

  logic       clk = 0;
  logic       reset;
  logic       tx_en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_ovf;
  logic       tx_done;
  logic       tx_te;
  logic [7:0] tx_dr;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
`ifdef UART_TX_FIFO_AFULL_EN
  logic       almost_full;
`endif

  uart_tx_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .tx_en    (tx_en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .tx_done  (tx_done),
    .tx_te    (tx_te),
    .tx_dr    (tx_dr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
`ifdef UART_TX_FIFO_AFULL_EN
    .almost_full (almost_full),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  bit         auto_done = 0;
  int         dmin = 1;
  int         dmax = 1;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b, input bit acc);
    wr_en   = 1;
    wr_data = b;
    @(posedge clk);
    if (acc) q.push_back(b);
    #1;
    wr_en = 0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int c = 0;
    while ((q.size() != 0 || busy || !empty) && c < maxc) begin
      tick();
      c++;
    end
    chk(nm, 32'(c < maxc), 1);
  endtask

  task automatic wait_te(input int maxc, input string nm);
    int c = 0;
    while (!tx_te && c < maxc) begin
      tick();
      c++;
    end
    chk(nm, 32'(tx_te), 1);
  endtask

  // transmitter model: ends each frame after a random delay
  initial begin
    int d;
    tx_done = 0;
    forever begin
      @(negedge clk);
      if (auto_done && tx_te && reset) begin
        d = $urandom_range(dmax, dmin);
        repeat (d) @(posedge clk);
        #2 tx_done = 1;
        @(posedge clk);
        #2 tx_done = 0;
      end
    end
  end

  // launch monitor
  bit         prev_te;
  bit         prev_done_te;
  bit         low_en;
  int         since_done;
  logic [7:0] held;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (!reset) begin
      prev_te      = 0;
      prev_done_te = 0;
      low_en       = 1;
      since_done   = 100;
    end else begin
      since_done++;
      chk("count_max", 32'(count <= 5'd16), 1);
      if (tx_te && !prev_te) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch got=%0h want=none t=%0t",
                   tx_dr, $time);
        end else begin
          exp_b = q.pop_front();
          chk("launch_data", 32'(tx_dr), 32'(exp_b));
        end
        chk("gap_low_en", 32'(low_en), 1);
        chk("done_to_rise", 32'(since_done >= 4), 1);
        held = tx_dr;
      end else if (tx_te) begin
        chk("dr_stable", 32'(tx_dr), 32'(held));
      end
      if (prev_done_te) chk("te_drop", 32'(tx_te), 0);
      prev_done_te = tx_done && tx_te;
      if (tx_te) low_en = 0;
      else if (tx_en) low_en = 1;
      if (tx_done) since_done = 0;
      prev_te = tx_te;
    end
  end

  initial begin
    int lat;
    int sent;
    int cyc;
    reset   = 0;
    tx_en   = 1;
    wr_en   = 0;
    wr_data = 0;
    flush   = 0;
    clr_ovf = 0;
    repeat (3) tick();
    chk("rst_te", 32'(tx_te), 0);
    chk("rst_dr", 32'(tx_dr), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1;
    tick();

    // single byte, launch latency
    auto_done = 1;
    dmin = 2;
    dmax = 2;
    write(8'hA5, 1);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (tx_te && lat == 0) lat = k;
    end
    chk("latency", 32'(lat), 3);
    chk("dr_a5", 32'(tx_dr), 'hA5);
    wait_idle(50, "idle_t1");
    chk("t1_empty", 32'(empty), 1);
    chk("t1_busy", 32'(busy), 0);

    // back-to-back frames
    dmin = 1;
    dmax = 20;
    write(8'h11, 1);
    write(8'h22, 1);
    write(8'h33, 1);
    wait_idle(300, "idle_t2");

    // fill to full, overflow handling
    auto_done = 0;
    write(8'h5A, 1);
    wait_te(20, "fill_launch");
    for (int i = 0; i < 16; i++) write(8'(i * 13 + 3), 1);
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(count), 16);
    write(8'hFF, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    clr_ovf = 1;
    write(8'hEE, 0);
    chk("ovf_set_wins", 32'(overflow), 1);
    tick();
    clr_ovf = 0;
    chk("ovf_clr", 32'(overflow), 0);
    auto_done = 1;
    wait_idle(800, "idle_t3");

    // wrap with random transmitter pacing
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || q.size() != 0 || busy) && cyc < 4000) begin
      tx_en = ($urandom_range(9, 0) < 8);
      if (sent < 40 && q.size() < 16 && $urandom_range(1, 0) == 1) begin
        write(8'($urandom), 1);
        sent++;
      end else begin
        tick();
      end
      cyc++;
    end
    tx_en = 1;
    chk("wrap_done", 32'(cyc < 4000), 1);
    wait_idle(200, "idle_t4");

    // flush during WAIT
    auto_done = 0;
    dmax = 10;
    for (int i = 0; i < 6; i++) write(8'(8'h40 + i), 1);
    wait_te(20, "flush_launch");
    repeat (3) tick();
    chk("pre_flush_cnt", 32'(count), 5);
    flush   = 1;
    wr_en   = 1;
    wr_data = 8'h77;
    tick();
    flush = 0;
    wr_en = 0;
    q.delete();
    chk("flush_cnt", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_te", 32'(tx_te), 1);
    auto_done = 1;
    repeat (40) tick();
    chk("flush_busy", 32'(busy), 0);
    chk("flush_te_end", 32'(tx_te), 0);

    // async reset mid-frame
    auto_done = 0;
    for (int i = 0; i < 3; i++) write(8'(8'h90 + i), 1);
    wait_te(20, "rst_launch");
    repeat (2) tick();
    #1 reset = 0;
    #1;
    chk("arst_te", 32'(tx_te), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_empty", 32'(empty), 1);
    q.delete();
    tick();
    reset = 1;
    tick();

`ifdef UART_TX_FIFO_AFULL_EN
    write(8'h01, 1);
    wait_te(20, "af_launch");
    for (int i = 0; i < 11; i++) write(8'(i), 1);
    chk("af_11", 32'(almost_full), 0);
    write(8'h0B, 1);
    chk("af_12", 32'(almost_full), 1);
    flush = 1;
    tick();
    flush = 0;
    q.delete();
    chk("af_flush", 32'(almost_full), 0);
    auto_done = 1;
    repeat (40) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
